// File: rtl/spi_readback_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_readback_responder                                          |
// | Function : decodes SPI read opcodes, snapshots a PWM bank register and     |
// |            streams it LSB-first onto the SPI slave TX port.                |
// | Options  : READBACK_CSUM_EN appends an XOR checksum byte to each readback.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_readback_responder #(
  parameter logic [7:0] CMD_BASE  = 8'h11,
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        o_RX_DV,
  input  logic [7:0]  o_RX_Byte,
  output logic        i_TX_DV,
  output logic [7:0]  i_TX_Byte,
  input  logic [31:0] counter_value,
  input  logic [31:0] prescaler,
  input  logic [31:0] duty_cycle_1,
  input  logic [31:0] duty_cycle_2,
  input  logic [31:0] duty_cycle_3,
  input  logic        enable_pwm,
  output logic        busy
);

`ifdef READBACK_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_WAIT   = 3'd2,
    S_FILL   = 3'd3,
    S_CSUM   = 3'd4,
    S_WAIT_C = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;
`endif

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_snapshot;
  logic        r_pending;

  logic [7:0]  w_offset;
  logic        w_cmd_hit;
  logic [31:0] w_sel_word;
  logic [7:0]  w_cur_byte;
  logic        w_advance;

  // Subtracting the base makes the range test immune to wrap-around.
  assign w_offset   = o_RX_Byte - CMD_BASE;
  assign w_cmd_hit  = (w_offset < 8'd6);
  assign w_cur_byte = r_snapshot[{r_idx, 3'b000} +: 8];
  assign w_advance  = o_RX_DV | r_pending;

  always_comb begin
    w_sel_word = 32'd0;
    case (w_offset[2:0])
      3'd0:    w_sel_word = counter_value;
      3'd1:    w_sel_word = prescaler;
      3'd2:    w_sel_word = duty_cycle_1;
      3'd3:    w_sel_word = duty_cycle_2;
      3'd4:    w_sel_word = duty_cycle_3;
      3'd5:    w_sel_word = {30'd0, 1'b1, enable_pwm};
      default: w_sel_word = 32'd0;
    endcase
  end

`ifdef READBACK_CSUM_EN
  logic [7:0] w_csum;
  assign w_csum = r_snapshot[7:0] ^ r_snapshot[15:8] ^ r_snapshot[23:16] ^ r_snapshot[31:24];
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_snapshot <= 32'd0;
      r_pending  <= 1'b0;
      i_TX_DV    <= 1'b0;
      i_TX_Byte  <= IDLE_FILL;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          i_TX_DV   <= 1'b0;
          r_pending <= 1'b0;
          if (o_RX_DV && w_cmd_hit) begin
            r_snapshot <= w_sel_word;
            r_idx      <= 2'd0;
            busy       <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          i_TX_DV   <= 1'b1;
          i_TX_Byte <= w_cur_byte;
          // An exchange finishing in a drive cycle must not be lost.
          r_pending <= r_pending | o_RX_DV;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          i_TX_DV <= 1'b0;
          if (w_advance) begin
            r_pending <= 1'b0;
            if (r_idx == 2'd3) begin
`ifdef READBACK_CSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_FILL;
`endif
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_SEND;
            end
          end
        end
`ifdef READBACK_CSUM_EN
        S_CSUM: begin
          i_TX_DV   <= 1'b1;
          i_TX_Byte <= w_csum;
          r_pending <= r_pending | o_RX_DV;
          r_state   <= S_WAIT_C;
        end
        S_WAIT_C: begin
          i_TX_DV <= 1'b0;
          if (w_advance) begin
            r_pending <= 1'b0;
            r_state   <= S_FILL;
          end
        end
`endif
        S_FILL: begin
          i_TX_DV   <= 1'b1;
          i_TX_Byte <= IDLE_FILL;
          busy      <= 1'b0;
          r_pending <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          i_TX_DV   <= 1'b0;
          i_TX_Byte <= IDLE_FILL;
          busy      <= 1'b0;
          r_pending <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
